// File: rtl/mem_arbiter.sv
// Two-port burst arbiter in front of a 2**ADDR_W x DATA_W shared memory.
// Round-robin between port 0 and port 1. A burst is never preempted, and at
// least one IDLE cycle separates consecutive bursts.
module mem_arbiter #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [1:0]        len0,
    input  logic [1:0]        len1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              busy
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t              state;
    logic                owner;      // port that owns the current burst
    logic                last;       // port that won the most recent arbitration
    logic                we_q;
    logic [ADDR_W-1:0]   baddr;      // address of the beat executing this cycle
    logic [1:0]          len_q;
    logic [1:0]          cnt;        // beats already completed in this burst

    logic [DATA_W-1:0]   mem [DEPTH];

    logic                win_c;
    logic                sel_we_c;
    logic [ADDR_W-1:0]   sel_addr_c;
    logic [1:0]          sel_len_c;
    logic                last_beat_c;
    logic                mem_we_c;
    logic [DATA_W-1:0]   mem_wdata_c;

    // Round-robin pick: on a tie the port that did not win last time wins
    always_comb begin
        win_c = 1'b0;
        if (req0 && req1) begin
            win_c = ~last;
        end else if (req1) begin
            win_c = 1'b1;
        end
    end

    // Burst descriptor of the winning port
    always_comb begin
        sel_we_c   = we0;
        sel_addr_c = addr0;
        sel_len_c  = len0;
        if (win_c) begin
            sel_we_c   = we1;
            sel_addr_c = addr1;
            sel_len_c  = len1;
        end
    end

    // Beat-level controls derived from the registered burst context
    always_comb begin
        last_beat_c = (cnt == len_q);
        mem_we_c    = (state == BURST) && we_q;
        mem_wdata_c = owner ? wdata1 : wdata0;
    end

    // Burst FSM: accepts a request in IDLE, runs one beat per BURST cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            owner   <= 1'b0;
            last    <= 1'b1;
            we_q    <= 1'b0;
            baddr   <= '0;
            len_q   <= '0;
            cnt     <= '0;
            gnt0    <= 1'b0;
            gnt1    <= 1'b0;
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            rdata0  <= '0;
            rdata1  <= '0;
            busy    <= 1'b0;
        end else begin
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        state <= BURST;
                        owner <= win_c;
                        last  <= win_c;
                        we_q  <= sel_we_c;
                        baddr <= sel_addr_c;
                        len_q <= sel_len_c;
                        cnt   <= '0;
                        gnt0  <= ~win_c;
                        gnt1  <= win_c;
                        busy  <= 1'b1;
                    end
                end
                BURST: begin
                    if (!we_q) begin
                        if (owner) begin
                            rdata1  <= mem[baddr];
                            rvalid1 <= 1'b1;
                        end else begin
                            rdata0  <= mem[baddr];
                            rvalid0 <= 1'b1;
                        end
                    end
                    baddr <= baddr + ADDR_W'(1);
                    cnt   <= cnt + 2'd1;
                    if (last_beat_c) begin
                        state <= IDLE;
                        gnt0  <= 1'b0;
                        gnt1  <= 1'b0;
                        busy  <= 1'b0;
                    end
                end
            endcase
        end
    end

    // Shared memory: reset loads i+1 (last word all ones); reset wins over a beat write
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= (i == int'(DEPTH) - 1) ? {DATA_W{1'b1}} : DATA_W'(i + 1);
            end
        end else if (mem_we_c) begin
            mem[baddr] <= mem_wdata_c;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Cycle-table bench for mem_arbiter plus hand-written wrap-around sequences.
module tb_mem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        req0, req1, we0, we1;
    logic [3:0]  addr0, addr1;
    logic [1:0]  len0, len1;
    logic [15:0] wdata0, wdata1;
    logic        gnt0, gnt1, rvalid0, rvalid1, busy;
    logic [15:0] rdata0, rdata1;

    int checks   = 0;
    int failures = 0;

    mem_arbiter #(.DATA_W(16), .ADDR_W(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req0    (req0),
        .req1    (req1),
        .we0     (we0),
        .we1     (we1),
        .addr0   (addr0),
        .addr1   (addr1),
        .len0    (len0),
        .len1    (len1),
        .wdata0  (wdata0),
        .wdata1  (wdata1),
        .gnt0    (gnt0),
        .gnt1    (gnt1),
        .rvalid0 (rvalid0),
        .rvalid1 (rvalid1),
        .rdata0  (rdata0),
        .rdata1  (rdata1),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One row = one clock cycle: inputs driven in that cycle, outputs seen in it
    typedef struct {
        logic        rst;
        logic        r0, r1, w0, w1;
        logic [3:0]  a0, a1;
        logic [1:0]  l0, l1;
        logic [15:0] d0, d1;
        logic [36:0] exp;   // {gnt0,gnt1,rvalid0,rvalid1,busy,rdata0,rdata1}
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input logic rst, input logic r0, input logic r1, input logic w0, input logic w1,
        input logic [3:0] a0, input logic [3:0] a1, input logic [1:0] l0, input logic [1:0] l1,
        input logic [15:0] d0, input logic [15:0] d1,
        input logic g0, input logic g1, input logic v0, input logic v1, input logic b,
        input logic [15:0] e0, input logic [15:0] e1);
        vec_t v;
        v.rst = rst; v.r0 = r0; v.r1 = r1; v.w0 = w0; v.w1 = w1;
        v.a0 = a0; v.a1 = a1; v.l0 = l0; v.l1 = l1; v.d0 = d0; v.d1 = d1;
        v.exp = {g0, g1, v0, v1, b, e0, e1};
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    logic [36:0] outs;
    logic [15:0] rd_q[$];

    initial begin
        rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        addr0 = '0; addr1 = '0; len0 = '0; len1 = '0; wdata0 = '0; wdata1 = '0;

        //            rst r0 r1 w0 w1 a0  a1  l0 l1 d0        d1         g0 g1 v0 v1 b  rdata0    rdata1
        // port 1 read from 14, len 3: wraps 15 -> 0 (row 0 is the reset state)
        vecs.push_back(mk(1, 0, 1, 0, 0, 0, 14, 0, 3, 16'h0,    16'h0,     0, 0, 0, 0, 0, 16'h0000, 16'h0000));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 14, 0, 3, 16'h0,    16'h0,     0, 1, 0, 0, 1, 16'h0000, 16'h0000));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 14, 0, 3, 16'h0,    16'h0,     0, 1, 0, 1, 1, 16'h0000, 16'h000F));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 14, 0, 3, 16'h0,    16'h0,     0, 1, 0, 1, 1, 16'h0000, 16'hFFFF));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 14, 0, 3, 16'h0,    16'h0,     0, 1, 0, 1, 1, 16'h0000, 16'h0001));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 14, 0, 3, 16'h0,    16'h0,     0, 0, 0, 1, 0, 16'h0000, 16'h0002));
        // port 0 read from 0, len 3
        vecs.push_back(mk(1, 1, 0, 0, 0, 0, 14, 3, 3, 16'h0,    16'h0,     0, 0, 0, 0, 0, 16'h0000, 16'h0002));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 14, 3, 3, 16'h0,    16'h0,     1, 0, 0, 0, 1, 16'h0000, 16'h0002));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 14, 3, 3, 16'h0,    16'h0,     1, 0, 1, 0, 1, 16'h0001, 16'h0002));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 14, 3, 3, 16'h0,    16'h0,     1, 0, 1, 0, 1, 16'h0002, 16'h0002));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 14, 3, 3, 16'h0,    16'h0,     1, 0, 1, 0, 1, 16'h0003, 16'h0002));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 14, 3, 3, 16'h0,    16'h0,     0, 0, 1, 0, 0, 16'h0004, 16'h0002));
        // reset (last winner was port 0), then both request len 0 and hold
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 16'h0,    16'h0,     0, 0, 0, 0, 0, 16'h0004, 16'h0002));
        vecs.push_back(mk(1, 1, 1, 0, 0, 2, 3,  0, 0, 16'h0,    16'h0,     0, 0, 0, 0, 0, 16'h0000, 16'h0000));
        vecs.push_back(mk(1, 1, 1, 0, 0, 2, 3,  0, 0, 16'h0,    16'h0,     1, 0, 0, 0, 1, 16'h0000, 16'h0000));
        vecs.push_back(mk(1, 1, 1, 0, 0, 2, 3,  0, 0, 16'h0,    16'h0,     0, 0, 1, 0, 0, 16'h0003, 16'h0000));
        vecs.push_back(mk(1, 1, 1, 0, 0, 2, 3,  0, 0, 16'h0,    16'h0,     0, 1, 0, 0, 1, 16'h0003, 16'h0000));
        vecs.push_back(mk(1, 1, 1, 0, 0, 2, 3,  0, 0, 16'h0,    16'h0,     0, 0, 0, 1, 0, 16'h0003, 16'h0004));
        vecs.push_back(mk(1, 1, 1, 0, 0, 2, 3,  0, 0, 16'h0,    16'h0,     1, 0, 0, 0, 1, 16'h0003, 16'h0004));
        vecs.push_back(mk(1, 0, 0, 0, 0, 2, 3,  0, 0, 16'h0,    16'h0,     0, 0, 1, 0, 0, 16'h0003, 16'h0004));
        // port 0 writes ABCD,1234 at 5; port 1 reads them back
        vecs.push_back(mk(1, 1, 0, 1, 0, 5, 0,  1, 0, 16'hABCD, 16'h0,     0, 0, 0, 0, 0, 16'h0003, 16'h0004));
        vecs.push_back(mk(1, 0, 0, 1, 0, 5, 0,  1, 0, 16'hABCD, 16'h0,     1, 0, 0, 0, 1, 16'h0003, 16'h0004));
        vecs.push_back(mk(1, 0, 0, 1, 0, 5, 0,  1, 0, 16'h1234, 16'h0,     1, 0, 0, 0, 1, 16'h0003, 16'h0004));
        vecs.push_back(mk(1, 0, 1, 1, 0, 5, 5,  1, 1, 16'h1234, 16'h0,     0, 0, 0, 0, 0, 16'h0003, 16'h0004));
        vecs.push_back(mk(1, 0, 0, 1, 0, 5, 5,  1, 1, 16'h1234, 16'h0,     0, 1, 0, 0, 1, 16'h0003, 16'h0004));
        vecs.push_back(mk(1, 0, 0, 1, 0, 5, 5,  1, 1, 16'h1234, 16'h0,     0, 1, 0, 1, 1, 16'h0003, 16'hABCD));
        vecs.push_back(mk(1, 0, 0, 1, 0, 5, 5,  1, 1, 16'h1234, 16'h0,     0, 0, 0, 1, 0, 16'h0003, 16'h1234));
        // port 0 read len 2 while req1 pulses mid-burst: no port 1 grant
        vecs.push_back(mk(1, 1, 0, 0, 0, 0, 5,  2, 1, 16'h0,    16'h0,     0, 0, 0, 0, 0, 16'h0003, 16'h1234));
        vecs.push_back(mk(1, 0, 1, 0, 0, 0, 5,  2, 1, 16'h0,    16'h0,     1, 0, 0, 0, 1, 16'h0003, 16'h1234));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 5,  2, 1, 16'h0,    16'h0,     1, 0, 1, 0, 1, 16'h0001, 16'h1234));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 5,  2, 1, 16'h0,    16'h0,     1, 0, 1, 0, 1, 16'h0002, 16'h1234));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 5,  2, 1, 16'h0,    16'h0,     0, 0, 1, 0, 0, 16'h0003, 16'h1234));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 5,  2, 1, 16'h0,    16'h0,     0, 0, 0, 0, 0, 16'h0003, 16'h1234));
        // port 1 write at 8 len 3, reset in its 2nd beat; memory comes back reinitialised
        vecs.push_back(mk(1, 0, 1, 0, 1, 0, 8,  0, 3, 16'h0,    16'h1111,  0, 0, 0, 0, 0, 16'h0003, 16'h1234));
        vecs.push_back(mk(1, 0, 0, 0, 1, 0, 8,  0, 3, 16'h0,    16'h1111,  0, 1, 0, 0, 1, 16'h0003, 16'h1234));
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 8,  0, 3, 16'h0,    16'h2222,  0, 1, 0, 0, 1, 16'h0003, 16'h1234));
        vecs.push_back(mk(1, 1, 0, 0, 1, 8, 8,  3, 3, 16'h0,    16'h2222,  0, 0, 0, 0, 0, 16'h0000, 16'h0000));
        vecs.push_back(mk(1, 0, 0, 0, 1, 8, 8,  3, 3, 16'h0,    16'h2222,  1, 0, 0, 0, 1, 16'h0000, 16'h0000));
        vecs.push_back(mk(1, 0, 0, 0, 1, 8, 8,  3, 3, 16'h0,    16'h2222,  1, 0, 1, 0, 1, 16'h0009, 16'h0000));
        vecs.push_back(mk(1, 0, 0, 0, 1, 8, 8,  3, 3, 16'h0,    16'h2222,  1, 0, 1, 0, 1, 16'h000A, 16'h0000));
        vecs.push_back(mk(1, 0, 0, 0, 1, 8, 8,  3, 3, 16'h0,    16'h2222,  1, 0, 1, 0, 1, 16'h000B, 16'h0000));
        vecs.push_back(mk(1, 0, 0, 0, 1, 8, 8,  3, 3, 16'h0,    16'h2222,  0, 0, 1, 0, 0, 16'h000C, 16'h0000));
        vecs.push_back(mk(1, 0, 0, 0, 0, 8, 8,  3, 3, 16'h0,    16'h0,     0, 0, 0, 0, 0, 16'h000C, 16'h0000));

        repeat (3) @(posedge clk);

        // Table: compare this cycle's outputs, then drive this cycle's inputs
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            outs = {gnt0, gnt1, rvalid0, rvalid1, busy, rdata0, rdata1};
            check($sformatf("row%0d", i), 64'(outs), 64'(vecs[i].exp));
            rst_n  = vecs[i].rst;
            req0   = vecs[i].r0;  req1   = vecs[i].r1;
            we0    = vecs[i].w0;  we1    = vecs[i].w1;
            addr0  = vecs[i].a0;  addr1  = vecs[i].a1;
            len0   = vecs[i].l0;  len1   = vecs[i].l1;
            wdata0 = vecs[i].d0;  wdata1 = vecs[i].d1;
        end

        // Port 0 write burst straddling the 15 -> 0 wrap
        @(negedge clk);
        req0 = 1'b1; we0 = 1'b1; addr0 = 4'd15; len0 = 2'd1; wdata0 = 16'h5A5A;
        @(negedge clk);
        req0 = 1'b0;
        check("wrap_wr_gnt_beat0", 64'(gnt0), 64'(1'b1));
        @(negedge clk);
        wdata0 = 16'hA5A5;
        check("wrap_wr_gnt_beat1", 64'({gnt0, gnt1}), 64'(2'b10));
        @(negedge clk);
        check("wrap_wr_done", 64'({gnt0, busy, rvalid0}), 64'(3'b000));

        // Port 1 reads the two wrapped words back, bounded wait
        req1 = 1'b1; we1 = 1'b0; addr1 = 4'd15; len1 = 2'd1;
        @(negedge clk);
        req1 = 1'b0;
        for (int c = 0; c < 12 && rd_q.size() < 2; c++) begin
            @(negedge clk);
            if (rvalid1) rd_q.push_back(rdata1);
        end
        check("wrap_rd_beats", 64'(rd_q.size()), 64'(2));
        if (rd_q.size() == 2) begin
            check("wrap_rd_word15", 64'(rd_q[0]), 64'(16'h5A5A));
            check("wrap_rd_word0",  64'(rd_q[1]), 64'(16'hA5A5));
        end
        @(negedge clk);
        check("wrap_rd_idle", 64'({gnt1, busy, rvalid1, rdata1}), 64'({3'b000, 16'hA5A5}));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog
    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
